// File: rtl/mem_port_arbiter.sv
// Two-port (CPU + debug/loader) arbiter in front of a single unified memory.
// Bounded-burst fairness under contention, registered read data with one-cycle latency.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_WR,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_Din,
  input  logic [DW-1:0] mem_Dout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE_CPU = 2'd1;
  localparam logic [1:0] SERVE_DBG = 2'd2;

  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_DBG = 1'b1;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    count_reg, count_next;
  logic          last_reg, last_next;
  logic          ready_reg;
  logic          cpu_rvalid_reg, dbg_rvalid_reg;
  logic [DW-1:0] cpu_rdata_reg, dbg_rdata_reg;

  logic          own_req, oth_req;
  logic [1:0]    oth_state;

  assign cpu_gnt    = (state_reg == SERVE_CPU) & cpu_req;
  assign dbg_gnt    = (state_reg == SERVE_DBG) & dbg_req;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign dbg_rvalid = dbg_rvalid_reg;
  assign cpu_rdata  = cpu_rdata_reg;
  assign dbg_rdata  = dbg_rdata_reg;

  // Serving-port view of the request lines, so both SERVE states share one rule set.
  assign own_req   = (state_reg == SERVE_CPU) ? cpu_req : dbg_req;
  assign oth_req   = (state_reg == SERVE_CPU) ? dbg_req : cpu_req;
  assign oth_state = (state_reg == SERVE_CPU) ? SERVE_DBG : SERVE_CPU;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    last_next  = last_reg;
    if (cpu_gnt) last_next = LAST_CPU;
    if (dbg_gnt) last_next = LAST_DBG;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        // ready_reg holds off the first grant until one full cycle after reset release.
        if (ready_reg) begin
          if (cpu_req && dbg_req)
            state_next = (last_reg == LAST_DBG) ? SERVE_CPU : SERVE_DBG;
          else if (cpu_req)
            state_next = SERVE_CPU;
          else if (dbg_req)
            state_next = SERVE_DBG;
        end
      end
      SERVE_CPU, SERVE_DBG: begin
        if (own_req && (!oth_req || (count_reg < BURST_LAST))) begin
          if (count_reg != 4'hF) count_next = count_reg + 4'd1;
        end else if (oth_req) begin
          state_next = oth_state;
          count_next = '0;
        end else begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_comb begin
    mem_WR   = 1'b0;
    mem_addr = '0;
    mem_Din  = '0;
    if (cpu_gnt) begin
      mem_WR   = cpu_we;
      mem_addr = cpu_addr;
      mem_Din  = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_WR   = dbg_we;
      mem_addr = dbg_addr;
      mem_Din  = dbg_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      last_reg       <= LAST_DBG;
      ready_reg      <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
      cpu_rdata_reg  <= '0;
      dbg_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      last_reg       <= last_next;
      ready_reg      <= 1'b1;
      cpu_rvalid_reg <= cpu_gnt & ~cpu_we;
      dbg_rvalid_reg <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_reg <= mem_Dout;
      if (dbg_gnt && !dbg_we) dbg_rdata_reg <= mem_Dout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queue-driven requesters, a transfer-level arbitration
// model checked every cycle, and directed literal checks for the key scenarios.
module tb_mem_port_arbiter;

  localparam int MB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_WR;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_Din, mem_Dout;

  logic [31:0] tb_mem [64];
  assign mem_Dout = tb_mem[mem_addr[7:2]];
  always @(posedge CLK) if (mem_WR) tb_mem[mem_addr[7:2]] <= mem_Din;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) u_dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_WR(mem_WR), .mem_addr(mem_addr), .mem_Din(mem_Din), .mem_Dout(mem_Dout)
  );

  // Second instance with MAX_BURST=1 for the strict-alternation scenario.
  logic        a_cpu_req = 1'b0, a_dbg_req = 1'b0;
  logic [31:0] a_cpu_addr = 32'h100, a_dbg_addr = 32'h200;
  logic [31:0] a_cpu_wdata = 32'h1111_0000, a_dbg_wdata = 32'h2222_0000;
  logic [31:0] a_mem_Dout = '0;
  logic        a_cpu_gnt, a_cpu_rvalid, a_cpu_stall, a_dbg_gnt, a_dbg_rvalid, a_mem_WR;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_addr, a_mem_Din;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) u_alt (
    .CLK(CLK), .RST(RST),
    .cpu_req(a_cpu_req), .cpu_we(1'b1), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dbg_req(a_dbg_req), .dbg_we(1'b1), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
    .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata),
    .mem_WR(a_mem_WR), .mem_addr(a_mem_addr), .mem_Din(a_mem_Din), .mem_Dout(a_mem_Dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- requesters ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  op_t cpu_q[$];
  op_t dbg_q[$];
  bit  cpu_en   = 1'b1;
  bit  cpu_seen = 1'b0;
  bit  dbg_seen = 1'b0;

  function automatic op_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  task automatic drive();
    op_t h;
    h = (cpu_q.size() != 0) ? cpu_q[0] : '0;
    cpu_req = cpu_en && (cpu_q.size() != 0);
    cpu_we = h.we; cpu_addr = h.addr; cpu_wdata = h.wdata;
    h = (dbg_q.size() != 0) ? dbg_q[0] : '0;
    dbg_req = (dbg_q.size() != 0);
    dbg_we = h.we; dbg_addr = h.addr; dbg_wdata = h.wdata;
  endtask

  // One clock: retire ops granted in the cycle just ended, present the next ones.
  task automatic cyc();
    @(posedge CLK);
    #1;
    if (cpu_seen && cpu_q.size() != 0) void'(cpu_q.pop_front());
    if (dbg_seen && dbg_q.size() != 0) void'(dbg_q.pop_front());
    drive();
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((cpu_q.size() != 0 || dbg_q.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    check_bit({tag, "_drained"}, n < 200, 1'b1);
    cyc();
    cyc();
  endtask

  // ---------------- transfer-level model ----------------
  // owner: 0 nobody, 1 cpu, 2 dbg; streak counts transfers since owner took over.
  int          owner = 0, streak = 0, last_port = 2;
  bit          armed = 1'b0;
  logic [31:0] model_mem [64];
  logic        exp_c_rv = 1'b0, exp_d_rv = 1'b0;
  logic [31:0] exp_c_rd = '0, exp_d_rd = '0;
  bit          m_gc, m_gd, m_mine, m_theirs;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner = 0; streak = 0; last_port = 2; armed = 1'b0;
      exp_c_rv = 1'b0; exp_d_rv = 1'b0; exp_c_rd = '0; exp_d_rd = '0;
    end else begin
      m_gc = (owner == 1) && cpu_req;
      m_gd = (owner == 2) && dbg_req;
      exp_c_rv = m_gc && !cpu_we;
      exp_d_rv = m_gd && !dbg_we;
      if (exp_c_rv) exp_c_rd = model_mem[cpu_addr[7:2]];
      if (exp_d_rv) exp_d_rd = model_mem[dbg_addr[7:2]];
      if (m_gc && cpu_we) model_mem[cpu_addr[7:2]] = cpu_wdata;
      if (m_gd && dbg_we) model_mem[dbg_addr[7:2]] = dbg_wdata;
      if (m_gc) last_port = 1;
      if (m_gd) last_port = 2;
      if (!armed) begin
        armed = 1'b1;
      end else if (owner == 0) begin
        streak = 0;
        if (cpu_req && dbg_req) owner = 3 - last_port;
        else if (cpu_req)       owner = 1;
        else if (dbg_req)       owner = 2;
      end else begin
        m_mine   = (owner == 1) ? cpu_req : dbg_req;
        m_theirs = (owner == 1) ? dbg_req : cpu_req;
        if (m_mine && (!m_theirs || streak + 1 < MB)) begin
          streak++;
        end else if (m_theirs) begin
          owner  = 3 - owner;
          streak = 0;
        end else begin
          owner  = 0;
          streak = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  string glog = "";
  int    cyc_no = 0;
  bit    e_gc, e_gd, e_wr;
  logic [31:0] e_addr, e_din;

  always @(negedge CLK) begin
    cyc_no++;
    e_gc   = (owner == 1) && cpu_req;
    e_gd   = (owner == 2) && dbg_req;
    e_wr   = e_gc ? cpu_we : (e_gd ? dbg_we : 1'b0);
    e_addr = e_gc ? cpu_addr : (e_gd ? dbg_addr : 32'h0);
    e_din  = e_gc ? cpu_wdata : (e_gd ? dbg_wdata : 32'h0);
    check_bit("cpu_gnt", cpu_gnt, e_gc);
    check_bit("dbg_gnt", dbg_gnt, e_gd);
    check_bit("cpu_stall", cpu_stall, cpu_req && !e_gc);
    check_bit("mem_WR", mem_WR, e_wr);
    check32("mem_addr", mem_addr, e_addr);
    check32("mem_Din", mem_Din, e_din);
    check_bit("cpu_rvalid", cpu_rvalid, exp_c_rv);
    check_bit("dbg_rvalid", dbg_rvalid, exp_d_rv);
    check32("cpu_rdata", cpu_rdata, exp_c_rd);
    check32("dbg_rdata", dbg_rdata, exp_d_rd);
    if (e_gc) $display("cycle %0d: cpu %s addr=%h wdata=%h", cyc_no, cpu_we ? "wr" : "rd", cpu_addr, cpu_wdata);
    if (e_gd) $display("cycle %0d: dbg %s addr=%h wdata=%h", cyc_no, dbg_we ? "wr" : "rd", dbg_addr, dbg_wdata);
    cpu_seen = cpu_gnt;
    dbg_seen = dbg_gnt;
    if (cpu_gnt) glog = {glog, "C"};
    if (dbg_gnt) glog = {glog, "D"};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int  n;
    bit  ok;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]    <= 32'hA500_0000 | i;
      model_mem[i]  = 32'hA500_0000 | i;
    end
    tb_mem[4]    <= 32'hDEAD_BEEF;
    model_mem[4]  = 32'hDEAD_BEEF;
    #1 RST = 1'b0;

    // Tie out of reset, then continuous contention with MAX_BURST=4.
    for (int i = 0; i < 10; i++) begin
      cpu_q.push_back(mk(1'b0, 32'(i * 4), 32'h0));
      dbg_q.push_back(mk(1'b0, 32'((16 + i) * 4), 32'h0));
    end
    drive();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_bit("rst_cpu_stall", cpu_stall, 1'b1);
      check_bit("rst_cpu_gnt", cpu_gnt, 1'b0);
      check32("rst_cpu_rdata", cpu_rdata, 32'h0);
    end
    RST  = 1'b1;
    glog = "";
    cyc();
    check_bit("first_edge_no_cpu_gnt", cpu_gnt, 1'b0);
    check_bit("first_edge_no_dbg_gnt", dbg_gnt, 1'b0);
    cyc();
    check_bit("tie_cpu_first", cpu_gnt, 1'b1);
    check_bit("tie_dbg_waits", dbg_gnt, 1'b0);
    drain("burst");
    n_checks++;
    if (glog != "CCCCDDDDCCCCDDDDCCDD") begin
      n_fail++;
      $display("FAIL burst_pattern: got %s, expected CCCCDDDDCCCCDDDDCCDD", glog);
    end

    // CPU-only read of 0x10 holding 0xDEADBEEF.
    cpu_q.push_back(mk(1'b0, 32'h10, 32'h0));
    drive();
    #1;
    check_bit("rd10_c0_stall", cpu_stall, 1'b1);
    check_bit("rd10_c0_gnt", cpu_gnt, 1'b0);
    cyc();
    check_bit("rd10_c1_gnt", cpu_gnt, 1'b1);
    check_bit("rd10_c1_stall", cpu_stall, 1'b0);
    check32("rd10_c1_addr", mem_addr, 32'h10);
    cyc();
    check_bit("rd10_c2_rvalid", cpu_rvalid, 1'b1);
    check32("rd10_c2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check_bit("rd10_c2_stall", cpu_stall, 1'b0);
    cyc();
    check_bit("rd10_c3_rvalid", cpu_rvalid, 1'b0);
    check32("rd10_c3_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    drain("rd10");

    // Loader write then CPU read-back.
    dbg_q.push_back(mk(1'b1, 32'h4, 32'h1234_5678));
    drive();
    drain("ldwr");
    check_bit("ldwr_no_rvalid", dbg_rvalid, 1'b0);
    cpu_q.push_back(mk(1'b0, 32'h4, 32'h0));
    drive();
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 10) begin
      cyc();
      if (cpu_rvalid) ok = 1'b1;
      n++;
    end
    check_bit("ldrd_rvalid_seen", ok, 1'b1);
    check32("ldrd_cpu_rdata", cpu_rdata, 32'h1234_5678);
    drain("ldrd");

    // CPU drops its request mid-burst while dbg waits.
    cpu_q.push_back(mk(1'b1, 32'h80, 32'hC0DE_0001));
    cpu_q.push_back(mk(1'b1, 32'h84, 32'hC0DE_0002));
    cpu_q.push_back(mk(1'b1, 32'h88, 32'hC0DE_0003));
    drive();
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 10) begin
      cyc();
      if (cpu_gnt) ok = 1'b1;
      n++;
    end
    check_bit("drop_cpu_started", ok, 1'b1);
    dbg_q.push_back(mk(1'b0, 32'h10, 32'h0));
    drive();
    cyc();
    check_bit("drop_cpu_second", cpu_gnt, 1'b1);
    cpu_en = 1'b0;
    cyc();
    check_bit("drop_no_cpu_gnt", cpu_gnt, 1'b0);
    check_bit("drop_no_dbg_gnt_yet", dbg_gnt, 1'b0);
    check_bit("drop_no_mem_WR", mem_WR, 1'b0);
    cyc();
    check_bit("drop_dbg_gnt_next", dbg_gnt, 1'b1);
    cpu_en = 1'b1;
    drive();
    drain("drop");

    // Reset asserted during a dbg write grant.
    dbg_q.push_back(mk(1'b1, 32'h8, 32'hCAFE_F00D));
    drive();
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 10) begin
      cyc();
      if (dbg_gnt) ok = 1'b1;
      n++;
    end
    check_bit("rstw_gnt_seen", ok, 1'b1);
    RST = 1'b0;
    #1;
    check_bit("rstw_mem_WR_drop", mem_WR, 1'b0);
    check_bit("rstw_dbg_gnt_drop", dbg_gnt, 1'b0);
    cyc();
    cyc();
    RST = 1'b1;
    cyc();
    check_bit("rstw_idle_gnt", dbg_gnt, 1'b0);
    check_bit("rstw_cpu_rvalid", cpu_rvalid, 1'b0);
    check_bit("rstw_dbg_rvalid", dbg_rvalid, 1'b0);
    check32("rstw_dbg_rdata", dbg_rdata, 32'h0);
    cyc();
    check_bit("rstw_retry_gnt", dbg_gnt, 1'b1);
    drain("rstw");
    check32("rstw_mem_written", tb_mem[2], 32'hCAFE_F00D);

    // MAX_BURST=1: both ports write continuously, strict alternation.
    a_cpu_req = 1'b1;
    a_dbg_req = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      check_bit("alt_mem_WR", a_mem_WR, 1'b1);
      check_bit("alt_cpu_gnt", a_cpu_gnt, (i % 2) == 0);
      check_bit("alt_dbg_gnt", a_dbg_gnt, (i % 2) == 1);
      check_bit("alt_cpu_stall", a_cpu_stall, (i % 2) == 1);
      check32("alt_mem_addr", a_mem_addr, ((i % 2) == 0) ? 32'h100 : 32'h200);
      check32("alt_mem_Din", a_mem_Din, ((i % 2) == 0) ? 32'h1111_0000 : 32'h2222_0000);
      check_bit("alt_no_rvalid", a_cpu_rvalid | a_dbg_rvalid, 1'b0);
      check32("alt_rdata_zero", a_cpu_rdata | a_dbg_rdata, 32'h0);
      cyc();
    end
    a_cpu_req = 1'b0;
    a_dbg_req = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive transfers to one port while the other port is waiting; legal range 1..15.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req, cpu_we  input  1 each  CPU port: access request and write enable.
REQ-007 cpu_addr  input  AW; cpu_wdata  input  DW  CPU port address and write data.
REQ-008 cpu_gnt  output  1; cpu_rvalid  output  1; cpu_rdata  output  DW  CPU port grant, read-data valid and read data.
REQ-009 cpu_stall  output  1  high when cpu_req=1 and cpu_gnt=0; drives the PC/IR enable gating.
REQ-010 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: the debug/loader port, with the same widths and meanings as the CPU port.
REQ-011 mem_WR  output  1; mem_addr  output  AW; mem_Din  output  DW  drive the unified memory (synchronous write, combinational read).
REQ-012 mem_Dout  input  DW  memory read data, valid in the same cycle as mem_addr.

Function
REQ-013 The FSM SHALL have three states: IDLE, SERVE_CPU and SERVE_DBG.
REQ-014 cpu_gnt SHALL equal (state==SERVE_CPU)&cpu_req, and dbg_gnt SHALL equal (state==SERVE_DBG)&dbg_req; both are combinational from registered state and are never high together.
REQ-015 A transfer SHALL occur in every cycle in which a gnt is high; the requester holds req, we, addr and wdata stable until it sees gnt.
REQ-016 During a transfer: mem_addr and mem_Din come from the granted port, and mem_WR = granted port's we; with no transfer: mem_WR=0, mem_addr=0, mem_Din=0.
REQ-017 Writes SHALL commit at the clock edge that ends the gnt cycle.
REQ-018 Reads: rdata SHALL capture mem_Dout at the edge ending the gnt cycle, and rvalid SHALL pulse high for exactly the following cycle (read latency 1 after gnt).
REQ-019 rdata SHALL hold its last value until the next read on that port; rvalid SHALL stay 0 after writes.
REQ-020 Grant latency: a request arriving while in IDLE SHALL be granted the cycle after it is first sampled.
REQ-021 IDLE transitions: no req -> IDLE; only one req -> SERVE of that port; both reqs -> SERVE of the port not recorded in the last-served register.
REQ-022 In SERVE_x, a 4-bit burst counter SHALL count transfers of x, starting at 0 on entry.
REQ-023 Leaving SERVE_x, the next state SHALL be:
  - SERVE_x, if req_x=1 and the other port is idle;
  - SERVE_x, if req_x=1, the other port requests and count < MAX_BURST-1;
  - SERVE_other, with counter reset to 0, if the other port requests;
  - IDLE otherwise.
REQ-024 Last-served SHALL update to x on every transfer of port x.
REQ-025 When both ports request continuously, the grant pattern SHALL be MAX_BURST transfers for one port followed by MAX_BURST for the other, and neither port waits more than MAX_BURST+1 cycles.
REQ-026 If req_x drops in SERVE_x, no transfer occurs that cycle and the FSM SHALL leave SERVE_x at the next edge.
REQ-027 MAX_BURST=1 SHALL yield strict alternation under contention.

Reset
REQ-028 While RST=0: state=IDLE, last-served=DBG (so the CPU wins the first tie), counter=0, rvalid=0, rdata=0, and all gnt, mem_WR and stall-free outputs at 0; cpu_stall follows cpu_req.
REQ-029 Reset asserted during a grant cycle SHALL drop mem_WR immediately; an in-flight read is discarded with no rvalid pulse.
REQ-030 The first grant after RST rises SHALL come no earlier than the second rising edge of CLK.

Verification
REQ-031 CPU only: read addr 0x10 while memory holds 0xDEADBEEF -> cpu_gnt at cycle 1, cpu_rvalid at cycle 2 with cpu_rdata=0xDEADBEEF, cpu_stall=1 only in cycle 0.
REQ-032 Tie out of reset: both request reads -> CPU granted first; with MAX_BURST=4, grants follow C,C,C,C,D,D,D,D,C...
REQ-033 Loader write: dbg write 0x0000_0004 <- 0x12345678, then CPU read 0x4 -> cpu_rdata=0x12345678.
REQ-034 MAX_BURST=1, both requesting writes -> mem_WR is high every cycle and the ports alternate, with no idle cycle between.
REQ-035 RST pulled low during a dbg write grant -> mem_WR=0 in the same cycle, and after release state is IDLE with all rvalid=0.
REQ-036 cpu_req dropped mid-burst while dbg is waiting -> no CPU transfer, and dbg_gnt the next cycle.
